// File: rtl/joy_serial_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | joy_serial_reader                                                          |
// | Serial gamepad reader for 74HC165-style chains with debounce and presence. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module joy_serial_reader #(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 12,
    parameter int CLK_DIV  = 24,
    parameter int GAP      = 1000,
    parameter int DEBOUNCE = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    joy_data,
    output logic                    joy_clk,
    output logic                    joy_load,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic [PLAYERS-1:0]      present,
    output logic                    frame_valid
);

    localparam int N     = PLAYERS * BITS;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int K_W   = $clog2(N + 1);
    localparam int GAP_W = $clog2(GAP + 1);
    localparam int HIST  = (DEBOUNCE > 1) ? DEBOUNCE - 1 : 1;

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   c_K_LAST   = K_W'(N - 1);
    localparam logic [GAP_W-1:0] c_GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0] c_GAP_ONE  = GAP_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_SHIFT  = 2'd2;
    localparam logic [1:0] c_UPDATE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             hi_q, hi_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [N-1:0]     raw_q, raw_d;
    logic [HIST-1:0][N-1:0] hist_q, hist_d;
    logic [N-1:0]     joy_q, joy_d;
    logic [PLAYERS-1:0] present_q, present_d;
    logic             fv_q, jclk_q, jclk_d, jload_q, jload_d;

    logic             w_frame_done;
    logic [PLAYERS-1:0] w_present;
    logic [N-1:0]     w_pmask;
    logic [N-1:0]     w_agree;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        hi_d    = hi_q;
        k_d     = k_q;
        gap_d   = gap_q;
        raw_d   = raw_q;
        case (state_q)
            c_IDLE: begin
                if (gap_q != '0) gap_d = gap_q - 1'b1;
                // Leaving on the count-of-one cycle keeps IDLE at exactly GAP cycles.
                if (enable && (gap_q <= c_GAP_ONE)) begin
                    state_d = c_LOAD;
                    div_d   = c_DIV_LAST;
                end
            end
            c_LOAD: begin
                if (div_q == '0) begin
                    state_d = c_SHIFT;
                    div_d   = c_DIV_LAST;
                    hi_d    = 1'b0;
                    k_d     = '0;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            c_SHIFT: begin
                if (div_q == '0) begin
                    div_d = c_DIV_LAST;
                    if (!hi_q) begin
                        hi_d       = 1'b1;
                        raw_d[k_q] = ~joy_data;
                    end else if (k_q == c_K_LAST) begin
                        state_d = c_UPDATE;
                        hi_d    = 1'b0;
                    end else begin
                        hi_d = 1'b0;
                        k_d  = k_q + 1'b1;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            c_UPDATE: begin
                state_d = c_IDLE;
                gap_d   = c_GAP_LOAD;
            end
            default: state_d = c_IDLE;
        endcase
        jclk_d  = (state_d == c_SHIFT) && hi_d;
        jload_d = (state_d != c_LOAD);
    end

    assign w_frame_done = (state_q == c_UPDATE);

    // A pad whose slice reads all-ones (every wire bit low) is treated as unplugged.
    for (genvar p = 0; p < PLAYERS; p++) begin : g_pad
        assign w_present[p]              = ~&raw_q[p*BITS +: BITS];
        assign w_pmask[p*BITS +: BITS]   = {BITS{w_present[p]}};
    end

    always_comb begin
        w_agree = '1;
        for (int i = 0; i < DEBOUNCE - 1; i++) begin
            w_agree &= ~(hist_q[i] ^ raw_q);
        end
    end

    always_comb begin
        hist_d    = hist_q;
        joy_d     = joy_q;
        present_d = present_q;
        if (w_frame_done) begin
            hist_d[0] = raw_q & w_pmask;
            for (int i = 1; i < HIST; i++) begin
                hist_d[i] = hist_q[i-1] & w_pmask;
            end
            joy_d     = w_pmask & ((w_agree & raw_q) | (~w_agree & joy_q));
            present_d = w_present;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= c_IDLE;
            div_q     <= '0;
            hi_q      <= 1'b0;
            k_q       <= '0;
            gap_q     <= '0;
            raw_q     <= '0;
            hist_q    <= '0;
            joy_q     <= '0;
            present_q <= '0;
            fv_q      <= 1'b0;
            jclk_q    <= 1'b0;
            jload_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            hi_q      <= hi_d;
            k_q       <= k_d;
            gap_q     <= gap_d;
            raw_q     <= raw_d;
            hist_q    <= hist_d;
            joy_q     <= joy_d;
            present_q <= present_d;
            fv_q      <= w_frame_done;
            jclk_q    <= jclk_d;
            jload_q   <= jload_d;
        end
    end

    assign joy_clk     = jclk_q;
    assign joy_load    = jload_q;
    assign joystick    = joy_q;
    assign present     = present_q;
    assign frame_valid = fv_q;

endmodule
`default_nettype wire
